// File: rtl/dram_multibank_read_ctrl_if.sv
// Request/response bundle for the multi-bank DRAM timing model.
// The master drives requests; the slave (controller) returns responses and statistics.
interface dram_multibank_read_ctrl_if #(
   parameter int unsigned BANK_W = 2,
   parameter int unsigned ROW_W  = 4,
   parameter int unsigned DATA_W = 16
);
   localparam int unsigned CNT_W = 16;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [BANK_W-1:0] req_bank;
   logic [ROW_W-1:0]  req_row;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_data;
   logic [1:0]        resp_kind;
   logic [CNT_W-1:0]  hit_cnt;
   logic [CNT_W-1:0]  miss_cnt;
   logic [CNT_W-1:0]  conf_cnt;

   modport master (
      output req_valid, req_we, req_bank, req_row, req_wdata,
      input  req_ready, resp_valid, resp_data, resp_kind, hit_cnt, miss_cnt, conf_cnt
   );

   modport slave (
      input  req_valid, req_we, req_bank, req_row, req_wdata,
      output req_ready, resp_valid, resp_data, resp_kind, hit_cnt, miss_cnt, conf_cnt
   );
endinterface

// File: rtl/dram_multibank_read_ctrl.sv
// Bank-level DRAM timing model: per-bank open-row buffer, hit/miss/conflict
// classification with per-class response latency, storage and statistics.
module dram_multibank_read_ctrl #(
   parameter int unsigned NUM_BANKS  = 4,
   parameter int unsigned ROW_W      = 4,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned HIT_LAT    = 1,
   parameter int unsigned MISS_LAT   = 2,
   parameter int unsigned CONF_LAT   = 3,
   parameter bit          CLOSE_PAGE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   dram_multibank_read_ctrl_if.slave bus
);
   localparam int unsigned BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int unsigned ADDR_W  = BANK_W + ROW_W;
   localparam int unsigned DEPTH   = 1 << ADDR_W;
   localparam int unsigned NB      = 1 << BANK_W;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned MAX_HM  = (HIT_LAT > MISS_LAT) ? HIT_LAT : MISS_LAT;
   localparam int unsigned MAX_LAT = (MAX_HM > CONF_LAT) ? MAX_HM : CONF_LAT;
   localparam int unsigned LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   localparam logic [1:0] KIND_HIT  = 2'b00;
   localparam logic [1:0] KIND_MISS = 2'b01;
   localparam logic [1:0] KIND_CONF = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e              state_q;
   logic [LAT_W-1:0]    lat_cnt_q;
   logic                req_ready_q;
   logic                resp_valid_q;
   logic [DATA_W-1:0]   resp_data_q;
   logic [1:0]          resp_kind_q;
   logic [DATA_W-1:0]   pend_data_q;
   logic [1:0]          pend_kind_q;
   logic [CNT_W-1:0]    hit_cnt_q;
   logic [CNT_W-1:0]    miss_cnt_q;
   logic [CNT_W-1:0]    conf_cnt_q;
   logic [NB-1:0]       open_valid_q;
   logic [ROW_W-1:0]    open_row_q [NB];
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                accept_c;
   logic [ADDR_W-1:0]   addr_c;
   logic [1:0]          kind_c;
   logic [LAT_W-1:0]    lat_c;
   logic [DATA_W-1:0]   data_c;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // Classify the incoming request against the target bank's open row.
   always_comb begin
      accept_c = bus.req_valid && req_ready_q;
      addr_c   = {bus.req_bank, bus.req_row};
      kind_c   = KIND_CONF;
      lat_c    = LAT_W'(CONF_LAT - 1);
      if (CLOSE_PAGE || !open_valid_q[bus.req_bank]) begin
         kind_c = KIND_MISS;
         lat_c  = LAT_W'(MISS_LAT - 1);
      end else if (open_row_q[bus.req_bank] == bus.req_row) begin
         kind_c = KIND_HIT;
         lat_c  = LAT_W'(HIT_LAT - 1);
      end
      data_c = bus.req_we ? bus.req_wdata : mem_q[addr_c];
   end

   // Response sequencing; payload is latched at acceptance and published on entry to RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         lat_cnt_q    <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_kind_q  <= '0;
         pend_data_q  <= '0;
         pend_kind_q  <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_RESP: begin
               if (accept_c) begin
                  state_q     <= ST_WAIT;
                  lat_cnt_q   <= lat_c;
                  pend_data_q <= data_c;
                  pend_kind_q <= kind_c;
                  req_ready_q <= 1'b0;
               end else begin
                  state_q     <= ST_IDLE;
                  req_ready_q <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (lat_cnt_q == '0) begin
                  state_q      <= ST_RESP;
                  resp_valid_q <= 1'b1;
                  resp_data_q  <= pend_data_q;
                  resp_kind_q  <= pend_kind_q;
                  req_ready_q  <= 1'b1;
               end else begin
                  lat_cnt_q <= lat_cnt_q - LAT_W'(1);
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Row buffer, storage and statistics all update on the acceptance edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         open_valid_q <= '0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
         conf_cnt_q   <= '0;
         for (int unsigned b = 0; b < NB; b++) begin
            open_row_q[b] <= '0;
         end
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= DATA_W'(i);
         end
      end else if (accept_c) begin
         open_row_q[bus.req_bank]   <= bus.req_row;
         open_valid_q[bus.req_bank] <= !CLOSE_PAGE;
         if (bus.req_we) begin
            mem_q[addr_c] <= bus.req_wdata;
         end
         case (kind_c)
            KIND_HIT:  hit_cnt_q  <= sat_inc(hit_cnt_q);
            KIND_MISS: miss_cnt_q <= sat_inc(miss_cnt_q);
            default:   conf_cnt_q <= sat_inc(conf_cnt_q);
         endcase
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_kind  = resp_kind_q;
   assign bus.hit_cnt    = hit_cnt_q;
   assign bus.miss_cnt   = miss_cnt_q;
   assign bus.conf_cnt   = conf_cnt_q;
endmodule

// File: tb/tb_dram_multibank_read_ctrl.sv
// Directed bench for dram_multibank_read_ctrl: open-page instance (a) and
// closed-page instance (b) sharing the request stimulus.
module tb_dram_multibank_read_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, sel, vld, we;
   logic [1:0]  bank;
   logic [3:0]  row;
   logic [15:0] wdata;
   int          n_chk = 0;
   int          n_pass = 0;

   dram_multibank_read_ctrl_if #(.BANK_W(2), .ROW_W(4), .DATA_W(16)) ifa ();
   dram_multibank_read_ctrl_if #(.BANK_W(2), .ROW_W(4), .DATA_W(16)) ifb ();

   assign ifa.req_valid = vld & ~sel;
   assign ifa.req_we    = we;
   assign ifa.req_bank  = bank;
   assign ifa.req_row   = row;
   assign ifa.req_wdata = wdata;
   assign ifb.req_valid = vld & sel;
   assign ifb.req_we    = we;
   assign ifb.req_bank  = bank;
   assign ifb.req_row   = row;
   assign ifb.req_wdata = wdata;

   dram_multibank_read_ctrl #(.CLOSE_PAGE(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   dram_multibank_read_ctrl #(.CLOSE_PAGE(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   logic        m_rv, m_rdy;
   logic [15:0] m_data, m_hit, m_miss, m_conf;
   logic [1:0]  m_kind;
   assign m_rv   = sel ? ifb.resp_valid : ifa.resp_valid;
   assign m_rdy  = sel ? ifb.req_ready  : ifa.req_ready;
   assign m_data = sel ? ifb.resp_data  : ifa.resp_data;
   assign m_kind = sel ? ifb.resp_kind  : ifa.resp_kind;
   assign m_hit  = sel ? ifb.hit_cnt    : ifa.hit_cnt;
   assign m_miss = sel ? ifb.miss_cnt   : ifa.miss_cnt;
   assign m_conf = sel ? ifb.conf_cnt   : ifa.conf_cnt;

   typedef struct {
      logic        we;
      logic [1:0]  bank;
      logic [3:0]  row;
      logic [15:0] wdata;
      logic [1:0]  kind;
      logic [15:0] data;
      int          lat;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Issue one request, scramble the fields after acceptance, then time the response.
   task automatic do_req(input vec_t v, input string tag);
      int  lat;
      bit  seen;
      @(negedge clk);
      for (int i = 0; i < 20 && !m_rdy; i++) @(negedge clk);
      vld = 1'b1; we = v.we; bank = v.bank; row = v.row; wdata = v.wdata;
      @(posedge clk);
      @(negedge clk);
      vld = 1'b0; we = ~v.we; bank = ~v.bank; row = ~v.row; wdata = ~v.wdata;
      lat = 0; seen = 1'b0;
      for (int i = 1; i <= 10 && !seen; i++) begin
         @(posedge clk); #1;
         if (m_rv) begin seen = 1'b1; lat = i; end
      end
      chk({tag, " latency"}, 32'(lat), 32'(v.lat));
      chk({tag, " data"}, 32'(m_data), 32'(v.data));
      chk({tag, " kind"}, 32'(m_kind), 32'(v.kind));
      we = 1'b0;
   endtask

   initial begin
      bit   seen;
      vec_t v;
      //        we    bank  row    wdata     kind   data      lat
      tbl[0] = '{1'b0, 2'd0, 4'd1,  16'h0000, 2'b01, 16'h0001, 2};
      tbl[1] = '{1'b0, 2'd0, 4'd2,  16'h0000, 2'b10, 16'h0002, 3};
      tbl[2] = '{1'b0, 2'd0, 4'd2,  16'h0000, 2'b00, 16'h0002, 1};
      tbl[3] = '{1'b1, 2'd2, 4'd11, 16'hBEEF, 2'b01, 16'hBEEF, 2};
      tbl[4] = '{1'b0, 2'd2, 4'd11, 16'h0000, 2'b00, 16'hBEEF, 1};
      tbl[5] = '{1'b0, 2'd3, 4'd11, 16'h0000, 2'b01, 16'h003B, 2};
      tbl[6] = '{1'b0, 2'd3, 4'd4,  16'h0000, 2'b10, 16'h0034, 3};
      tbl[7] = '{1'b1, 2'd3, 4'd4,  16'h1234, 2'b00, 16'h1234, 1};
      tbl[8] = '{1'b0, 2'd0, 4'd2,  16'h0000, 2'b00, 16'h0002, 1};
      tbl[9] = '{1'b0, 2'd1, 4'd15, 16'h0000, 2'b01, 16'h001F, 2};

      rst = 1'b1; sel = 1'b0; vld = 1'b0; we = 1'b0; bank = '0; row = '0; wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      chk("reset ready", 32'(m_rdy), 32'd1);
      chk("reset resp_valid", 32'(m_rv), 32'd0);
      chk("reset resp_data", 32'(m_data), 32'd0);
      chk("reset resp_kind", 32'(m_kind), 32'd0);
      chk("reset counters", {m_hit, m_miss | m_conf}, 32'd0);

      for (int i = 0; i < 10; i++) do_req(tbl[i], $sformatf("vec%0d", i));
      chk("hit_cnt after table", 32'(m_hit), 32'd4);
      chk("miss_cnt after table", 32'(m_miss), 32'd4);
      chk("conf_cnt after table", 32'(m_conf), 32'd2);

      repeat (2) @(posedge clk); #1;
      chk("hold resp_valid low", 32'(m_rv), 32'd0);
      chk("hold resp_data", 32'(m_data), 32'h001F);
      chk("hold resp_kind", 32'(m_kind), 32'd1);

      // Back-to-back hits on bank 1 with req_valid held high.
      @(negedge clk);
      vld = 1'b1; we = 1'b0; bank = 2'd1; row = 4'd15;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         chk($sformatf("b2b resp_valid k%0d", k), 32'(m_rv), 32'((k % 2) == 0));
         chk($sformatf("b2b ready k%0d", k), 32'(m_rdy), 32'((k % 2) == 0));
         if ((k % 2) == 0) chk($sformatf("b2b data k%0d", k), 32'(m_data), 32'h001F);
      end
      @(negedge clk); vld = 1'b0;
      @(negedge clk);
      chk("b2b hit_cnt", 32'(m_hit), 32'd7);

      // Reset during the WAIT of a conflict aborts the response.
      for (int i = 0; i < 20 && !m_rdy; i++) @(negedge clk);
      vld = 1'b1; bank = 2'd1; row = 4'd3;
      @(posedge clk);
      @(negedge clk); vld = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      chk("rst ready", 32'(m_rdy), 32'd1);
      chk("rst counters", {m_hit, m_miss | m_conf}, 32'd0);
      @(negedge clk); rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (m_rv) seen = 1'b1;
      end
      chk("rst no resp", 32'(seen), 32'd0);
      v = '{1'b0, 2'd1, 4'd3, 16'h0000, 2'b01, 16'h0013, 2};
      do_req(v, "post-rst reread");
      v = '{1'b0, 2'd3, 4'd4, 16'h0000, 2'b01, 16'h0034, 2};
      do_req(v, "post-rst storage");
      chk("post-rst miss_cnt", 32'(m_miss), 32'd2);

      // Closed-page instance: repeat access to the same row stays a miss.
      @(negedge clk);
      for (int i = 0; i < 20 && !m_rdy; i++) @(negedge clk);
      sel = 1'b1;
      v = '{1'b0, 2'd0, 4'd5, 16'h0000, 2'b01, 16'h0005, 2};
      do_req(v, "cp first");
      do_req(v, "cp second");
      @(negedge clk);
      chk("cp miss_cnt", 32'(m_miss), 32'd2);
      chk("cp hit_cnt", 32'(m_hit), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/dram_multibank_read_ctrl.md
Name: dram_multibank_read_ctrl

Overview:
- Parametrised multi-bank DRAM access model with a per-bank open-row buffer.
- Each request is classified as row hit, miss or conflict, and the response is returned after a configurable per-class latency.
- Adds write support, a valid/ready request handshake, an optional closed-page policy, and saturating hit/miss/conflict statistics counters.
- Sits between the CPU-side request generator and the memory test benches as the bank-level timing model.

Parameters:
- NUM_BANKS, 4, number of banks; power of two, 1 to 16.
- ROW_W, 4, row-index width; rows per bank = 2^ROW_W.
- DATA_W, 16, row data width; must be at least BANK_W+ROW_W.
- HIT_LAT, 1, cycles from acceptance edge to response for a hit; must be at least 1.
- MISS_LAT, 2, latency for a miss (bank has no open row); must be at least 1.
- CONF_LAT, 3, latency for a conflict (different row open); must be at least 1.
- CLOSE_PAGE, 0, 1 = row closed after every access, so every access is a miss.
- BANK_W, derived as log2(NUM_BANKS), minimum 1; not user-set.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_bank  in  BANK_W  target bank.
- req_row  in  ROW_W  target row.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle response pulse.
- resp_data  out  DATA_W  read data, or the written data for a write.
- resp_kind  out  2  00 hit, 01 miss, 10 conflict.
- hit_cnt, miss_cnt, conf_cnt  out  16 each  saturating access counters.

Behaviour:
- Reset:
  - All outputs 0 except req_ready = 1.
  - FSM returns to IDLE; all open_valid bits cleared; counters cleared.
  - Storage word (b,r) initialised to {b,r} zero-extended to DATA_W.
  - Reset mid-request aborts the request: no resp_valid, and a pending write is discarded if not yet committed.
- Acceptance:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - All request fields are captured at that edge; later changes are ignored.
- Classification at acceptance:
  - Miss if !open_valid[bank] or CLOSE_PAGE = 1.
  - Hit if open_valid[bank] and open_row[bank] == req_row.
  - Conflict otherwise.
  - The matching counter increments at the acceptance edge and saturates at 16'hFFFF.
- Row buffer:
  - At acceptance, open_row[bank] <= req_row and open_valid[bank] <= !CLOSE_PAGE.
  - Other banks are unaffected; banks hold open rows independently.
- Write commit: storage is written at the acceptance edge; resp_data = captured req_wdata.
- Read data: sampled from storage at the acceptance edge.
- FSM states:
  - IDLE: req_ready = 1. On accept, load lat_cnt = LAT-1 and go to WAIT.
  - WAIT: req_ready = 0. If lat_cnt == 0, go to RESP; else decrement lat_cnt.
  - RESP: resp_valid = 1 for exactly this cycle, with resp_data and resp_kind valid. req_ready = 1 here, so a new request may be accepted at the end of RESP and goes directly to WAIT.
  - RESP with no new request goes to IDLE.
- Latency:
  - An accepted request at edge E0 produces a RESP cycle that begins at edge E0+LAT.
  - Throughput is one request per LAT+1 cycles back-to-back.
- Hold values: resp_data and resp_kind hold their last values outside RESP; only resp_valid qualifies them.
- Bound-free inputs: req_bank and req_row are always in range by width; no error path.
- Simultaneous events: reset dominates acceptance and any counter increment in the same cycle.

Test Plan:
- Reset, then read bank 0 row 1 → miss; resp_valid at acceptance edge +2; resp_data = 16'h0001; resp_kind = 01; miss_cnt = 1.
- Read bank 0 row 2, then bank 0 row 2 again → first is a conflict (resp at +3, data 16'h0002, kind 10); second is a hit (resp at +1, kind 00); conf_cnt = 1, hit_cnt = 1.
- Write bank 2 row 11 with 16'hBEEF (miss), then read bank 2 row 11 → hit; resp_data = 16'hBEEF; read of bank 3 row 11 still returns 16'h003B (bank independence).
- Hold req_valid high with back-to-back hits on bank 1 → req_ready low during WAIT; a new acceptance in each RESP cycle; resp_valid pulses every 2 cycles.
- Assert rst in the WAIT of a conflict → no resp_valid; req_ready = 1 next cycle; counters = 0; a re-read of the same row is a miss.
- With CLOSE_PAGE = 1, read bank 0 row 5 twice → both misses; miss_cnt = 2; hit_cnt = 0.
